// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM port among NCORES cores.
// One access at a time: IDLE latches the winner, ISSUE strobes DRAM, WAIT covers read latency, ACK pulses the winner.
module dram_arbiter #(
    parameter int WIDTH  = 8,
    parameter int NCORES = 2,
    parameter int RD_LAT = 1
) (
    input  logic                      Clk,
    input  logic                      RST,
    input  logic [NCORES-1:0]         core_rd,
    input  logic [NCORES-1:0]         core_wr,
    input  logic [NCORES*WIDTH-1:0]   core_addr,
    input  logic [NCORES*WIDTH-1:0]   core_wdata,
    output logic [WIDTH-1:0]          core_rdata,
    output logic [NCORES-1:0]         core_grant,
    output logic [NCORES-1:0]         core_ack,
    output logic [WIDTH-1:0]          dram_addr,
    output logic [WIDTH-1:0]          dram_wdata,
    output logic                      dram_rd,
    output logic                      dram_wr,
    input  logic [WIDTH-1:0]          dram_rdata
);

    localparam int unsigned NC = NCORES;
    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int CW = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(RD_LAT - 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(NCORES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t            state, state_next;
    logic [IW-1:0]     last;
    logic [IW-1:0]     winner;
    logic              op_wr;
    logic [CW-1:0]     cnt;

    logic [NCORES-1:0] req;
    logic [IW-1:0]     pick;
    logic              pick_valid;
    int unsigned       idx;
    logic [WIDTH-1:0]  sel_addr;
    logic [WIDTH-1:0]  sel_wdata;
    logic              sel_wr;

    always_comb begin
        req = core_rd | core_wr;
    end

    // Search starts just after the last winner and wraps, so core 0 leads after reset.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        idx        = 0;
        for (int unsigned k = 1; k <= NC; k++) begin
            idx = (32'(last) + k) % NC;
            if (!pick_valid && req[IW'(idx)]) begin
                pick_valid = 1'b1;
                pick       = IW'(idx);
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int unsigned k = 0; k < NC; k++) begin
            if (pick == IW'(k)) begin
                sel_addr  = core_addr[k*WIDTH +: WIDTH];
                sel_wdata = core_wdata[k*WIDTH +: WIDTH];
                sel_wr    = core_wr[k];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            state      <= IDLE;
            last       <= LAST_INIT;
            winner     <= '0;
            op_wr      <= 1'b0;
            cnt        <= '0;
            dram_addr  <= '0;
            dram_wdata <= '0;
            core_grant <= '0;
            core_rdata <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        winner     <= pick;
                        op_wr      <= sel_wr;
                        dram_addr  <= sel_addr;
                        dram_wdata <= sel_wdata;
                        core_grant <= NCORES'(1) << pick;
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        core_rdata <= dram_rdata;
                    end
                end
                ACK: last <= winner;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        dram_rd    = 1'b0;
        dram_wr    = 1'b0;
        core_ack   = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                dram_wr    = op_wr;
                dram_rd    = !op_wr;
                state_next = op_wr ? ACK : WAIT;
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                core_ack   = NCORES'(1) << winner;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus random traffic against a transaction-level model.
// The bench also plays the DRAM, returning model memory contents RD_LAT cycles after each read strobe.
module tb_dram_arbiter;

    localparam int W  = 8;
    localparam int NC = 3;
    localparam int RL = 2;

    logic            Clk = 1'b0;
    logic            RST;
    logic [NC-1:0]   core_rd, core_wr, core_grant, core_ack;
    logic [NC*W-1:0] core_addr, core_wdata;
    logic [W-1:0]    core_rdata, dram_addr, dram_wdata, dram_rdata;
    logic            dram_rd, dram_wr;

    dram_arbiter #(.WIDTH(W), .NCORES(NC), .RD_LAT(RL)) dut (
        .Clk        (Clk),
        .RST        (RST),
        .core_rd    (core_rd),
        .core_wr    (core_wr),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_grant (core_grant),
        .core_ack   (core_ack),
        .dram_addr  (dram_addr),
        .dram_wdata (dram_wdata),
        .dram_rd    (dram_rd),
        .dram_wr    (dram_wr),
        .dram_rdata (dram_rdata)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Transaction model: one access in flight, described by its start cycle and kind.
    bit            m_act;
    int            m_start, m_done, m_win, m_last;
    bit            m_wr;
    logic [W-1:0]  m_a, m_d, m_da, m_dw, m_rdata;
    logic [NC-1:0] m_grant, m_ack_prev;
    logic [W-1:0]  mem [256];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_act   = 1'b0;
        m_last  = NC - 1;
        m_grant = '0;
        m_da    = '0;
        m_dw    = '0;
        m_rdata = '0;
    endtask

    task automatic step();
        logic [NC-1:0] exp_ack;
        bit            exp_rd, exp_wr, found;
        int            w, j;
        @(negedge Clk);
        exp_rd  = m_act && !m_wr && (cyc == m_start + 1);
        exp_wr  = m_act &&  m_wr && (cyc == m_start + 1);
        exp_ack = (m_act && cyc == m_done) ? NC'(1 << m_win) : '0;
        chk("dram_rd",    dram_rd,    exp_rd);
        chk("dram_wr",    dram_wr,    exp_wr);
        chk("core_ack",   core_ack,   exp_ack);
        chk("core_grant", core_grant, m_grant);
        chk("dram_addr",  dram_addr,  m_da);
        chk("dram_wdata", dram_wdata, m_dw);
        chk("core_rdata", core_rdata, m_rdata);
        if (m_act && !m_wr && cyc == m_start + 1 + RL) dram_rdata = mem[m_a];
        else dram_rdata = W'($urandom);
        m_ack_prev = exp_ack;
        if (RST) begin
            model_reset();
        end else begin
            if (exp_wr) mem[m_a] = m_d;
            if (m_act && !m_wr && cyc == m_start + 1 + RL) m_rdata = dram_rdata;
            if (m_act && cyc == m_done) begin
                m_last = m_win;
                m_act  = 1'b0;
            end else if (!m_act) begin
                found = 1'b0;
                w     = 0;
                for (int k = 1; k <= NC; k++) begin
                    j = (m_last + k) % NC;
                    if (!found && (core_rd[j] || core_wr[j])) begin
                        found = 1'b1;
                        w     = j;
                    end
                end
                if (found) begin
                    m_act   = 1'b1;
                    m_win   = w;
                    m_wr    = core_wr[w];
                    m_a     = core_addr[w*W +: W];
                    m_d     = core_wdata[w*W +: W];
                    m_start = cyc;
                    m_done  = cyc + (m_wr ? 2 : 2 + RL);
                    m_grant = NC'(1 << w);
                    m_da    = m_a;
                    m_dw    = m_d;
                end
            end
        end
        cyc++;
        @(posedge Clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((core_rd != 0 || core_wr != 0 || m_act) && n < 60) begin
            step();
            n++;
            for (int i = 0; i < NC; i++) begin
                if (m_ack_prev[i]) begin
                    core_rd[i] = 1'b0;
                    core_wr[i] = 1'b0;
                end
            end
        end
        chk("drain_bound", 32'(n < 60), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd"},    dram_rd,    0);
        chk({tag, "_wr"},    dram_wr,    0);
        chk({tag, "_ack"},   core_ack,   0);
        chk({tag, "_grant"}, core_grant, 0);
        chk({tag, "_addr"},  dram_addr,  0);
        chk({tag, "_wdata"}, dram_wdata, 0);
        chk({tag, "_rdata"}, core_rdata, 0);
    endtask

    initial begin
        int order[$];
        int n;
        bit pend[NC];
        for (int i = 0; i < 256; i++) mem[i] = W'($urandom);
        mem[8'h20] = 8'h3C;
        model_reset();
        m_ack_prev = '0;
        RST        = 1'b1;
        core_rd    = NC'($urandom);
        core_wr    = NC'($urandom);
        core_addr  = (NC*W)'($urandom);
        core_wdata = (NC*W)'($urandom);
        dram_rdata = W'($urandom);

        // Reset held for two edges with random requests, then a 0/1 tie.
        @(posedge Clk);
        #1;
        chk_all_zero("rst1");
        core_rd = NC'($urandom);
        step();
        chk_all_zero("rst2");
        RST     = 1'b0;
        core_rd = 3'b011;
        core_wr = 3'b000;
        step();
        chk("tie_grant", core_grant, 3'b001);
        chk("tie_rd",    dram_rd,    1);
        drain();

        // Core 0 write.
        core_wr[0] = 1'b1;
        core_addr[0*W +: W]  = 8'h10;
        core_wdata[0*W +: W] = 8'hA5;
        step();
        chk("wr_strobe", dram_wr,    1);
        chk("wr_nord",   dram_rd,    0);
        chk("wr_addr",   dram_addr,  8'h10);
        chk("wr_data",   dram_wdata, 8'hA5);
        step();
        chk("wr_ack",    core_ack,   3'b001);
        core_wr[0] = 1'b0;
        step();
        chk("wr_idle_ack", core_ack, 3'b000);
        chk("wr_idle_wr",  dram_wr,  0);
        drain();

        // Core 1 read with latency 2.
        core_rd[1] = 1'b1;
        core_addr[1*W +: W] = 8'h20;
        step();
        chk("rd_strobe", dram_rd,   1);
        chk("rd_addr",   dram_addr, 8'h20);
        step();
        chk("rd_wait1_ack", core_ack, 3'b000);
        step();
        chk("rd_wait2_ack", core_ack, 3'b000);
        step();
        chk("rd_ack",   core_ack,   3'b010);
        chk("rd_data",  core_rdata, 8'h3C);
        core_rd[1] = 1'b0;
        drain();

        // Cores 0 and 1 request continuously.
        core_wr = 3'b011;
        n = 0;
        while (order.size() < 6 && n < 80) begin
            step();
            n++;
            for (int i = 0; i < NC; i++) if (core_ack[i] === 1'b1) order.push_back(i);
        end
        chk("rr_count", order.size(), 6);
        for (int k = 0; k < order.size() && k < 6; k++) chk("rr_order", order[k], k % 2);
        core_wr = 3'b000;
        drain();

        // Read and write together on core 0 behaves as a write.
        core_rd[0] = 1'b1;
        core_wr[0] = 1'b1;
        core_addr[0*W +: W]  = 8'h33;
        core_wdata[0*W +: W] = 8'h77;
        step();
        chk("rw_wr",   dram_wr,    1);
        chk("rw_nord", dram_rd,    0);
        chk("rw_data", dram_wdata, 8'h77);
        step();
        chk("rw_ack",   core_ack,   3'b001);
        chk("rw_rdata", core_rdata, 8'h3C);
        core_rd[0] = 1'b0;
        core_wr[0] = 1'b0;
        drain();

        // Reset during the wait of a core 1 read.
        core_rd[1] = 1'b1;
        core_addr[1*W +: W] = 8'h44;
        step();
        chk("ab_strobe", dram_rd, 1);
        step();
        RST = 1'b1;
        step();
        chk("ab_ack",   core_ack,   3'b000);
        chk("ab_rd",    dram_rd,    0);
        chk("ab_grant", core_grant, 3'b000);
        RST        = 1'b0;
        core_rd[1] = 1'b0;
        core_wr[0] = 1'b1;
        core_addr[0*W +: W]  = 8'h55;
        core_wdata[0*W +: W] = 8'h99;
        step();
        chk("ab_wr_strobe", dram_wr, 1);
        step();
        chk("ab_wr_ack", core_ack, 3'b001);
        core_wr[0] = 1'b0;
        drain();

        // Random traffic; cores hold requests until acked, occasional resets.
        for (int i = 0; i < NC; i++) pend[i] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            RST = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NC; i++) begin
                if (m_ack_prev[i]) begin
                    pend[i]    = 1'b0;
                    core_rd[i] = 1'b0;
                    core_wr[i] = 1'b0;
                end
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 2))
                        0: begin core_rd[i] = 1'b1; core_wr[i] = 1'b0; end
                        1: begin core_rd[i] = 1'b0; core_wr[i] = 1'b1; end
                        default: begin core_rd[i] = 1'b1; core_wr[i] = 1'b1; end
                    endcase
                    core_addr[i*W +: W]  = W'($urandom);
                    core_wdata[i*W +: W] = W'($urandom);
                    pend[i] = 1'b1;
                end else if (pend[i] && $urandom_range(0, 3) == 0) begin
                    core_addr[i*W +: W]  = W'($urandom);
                    core_wdata[i*W +: W] = W'($urandom);
                end
            end
            step();
        end
        RST     = 1'b0;
        core_rd = '0;
        core_wr = '0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
